// File: rtl/flipflop_t_counter_updown.sv
// Synchronous modulo-MODULO up/down counter built from T-type state cells.
// Per-bit toggle enables come from the current count; q_inverse is its own toggling register.
module flipflop_t_counter_updown #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MODULO = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_inverse,
  output logic             wrap,
  output logic             load_err
);

  localparam int unsigned EXT_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [EXT_W-1:0] MOD_EXT = EXT_W'(MODULO);

  logic [WIDTH-1:0] t_up_c;
  logic [WIDTH-1:0] t_dn_c;
  logic [WIDTH-1:0] t_c;
  logic             wrap_c;
  logic             load_ok_c;
  logic             at_max_c;
  logic             at_zero_c;

  // Classic T-counter enables: a bit toggles when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    logic carry_up;
    logic carry_dn;
    t_up_c   = '0;
    t_dn_c   = '0;
    carry_up = 1'b1;
    carry_dn = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      t_up_c[i] = carry_up;
      t_dn_c[i] = carry_dn;
      carry_up  = carry_up & q[i];
      carry_dn  = carry_dn & ~q[i];
    end
  end

  // Modulo override: at the range ends the toggle vector jumps straight to the wrap target.
  always_comb begin
    at_max_c  = (q == MAX_VAL);
    at_zero_c = (q == '0);
    t_c       = up ? t_up_c : t_dn_c;
    wrap_c    = 1'b0;
    if (up && at_max_c) begin
      t_c    = q;
      wrap_c = 1'b1;
    end else if (!up && at_zero_c) begin
      t_c    = MAX_VAL;
      wrap_c = 1'b1;
    end
  end

  assign load_ok_c = ({1'b0, load_value} < MOD_EXT);

  // Priority per edge: rst > load > en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      q_inverse <= '1;
      wrap      <= 1'b0;
      load_err  <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (load_ok_c) begin
        q         <= load_value;
        q_inverse <= ~load_value;
        load_err  <= 1'b0;
      end else begin
        load_err <= 1'b1;
      end
    end else if (en) begin
      q         <= q ^ t_c;
      q_inverse <= q_inverse ^ t_c;
      wrap      <= wrap_c;
      load_err  <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: doc/flipflop_t_counter_updown.md
Name: flipflop_t_counter_updown

Overview:
- Synchronous modulo-N up/down counter whose state bits are T-type cells.
- Per-bit toggle enables are derived from the current count, as in a classic synchronous T-flip-flop counter.
- Downstream consumer of the team's T flip-flop stage: it turns single-bit toggle cells into a loadable, wrap-aware multi-bit counter.
- Intended for clock-dividing and sequencing in neighbouring benches.

Parameters:
- WIDTH, 4, number of counter bits.
- MODULO, 10, count range 0..MODULO-1. Legal range: 2 <= MODULO <= 2^WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- load_value  input  WIDTH  value to load.
- q  output  WIDTH  current count (registered).
- q_inverse  output  WIDTH  bitwise complement of q (registered, never a combinational invert).
- wrap  output  1  registered one-cycle pulse; the previous edge wrapped the count.
- load_err  output  1  registered one-cycle pulse; the previous edge rejected a load.

Behaviour:
- Reset (rst=1 at posedge):
  - q=0, q_inverse={WIDTH{1}}, wrap=0, load_err=0.
  - Reset has priority over load and en.
  - Reset mid-count abandons the count immediately; no wrap pulse.
- Priority per edge: rst > load > en > hold.
- Load (load=1):
  - If load_value < MODULO: q<=load_value, q_inverse<=~load_value, load_err<=0.
  - Otherwise: q and q_inverse hold, load_err<=1 for exactly one cycle.
  - en is ignored on a load edge. wrap<=0 on any load edge.
- Count (en=1, load=0), T-cell toggle vector t[i]:
  - Up: t[0]=1; t[i] = AND of q[0..i-1].
  - Down: t[0]=1; t[i] = AND of ~q[0..i-1].
  - Each bit applies q[i] <= q[i] ^ t[i]; q_inverse[i] toggles identically.
- Modulo override:
  - Up with q==MODULO-1: next q=0 (t[i]=q[i]), wrap<=1.
  - Down with q==0: next q=MODULO-1 (t[i]=(MODULO-1)[i]), wrap<=1.
  - Otherwise wrap<=0.
- Hold (en=0, load=0): q and q_inverse unchanged; wrap<=0 and load_err<=0.
- Latency:
  - q reflects an action one edge after the inputs are sampled.
  - wrap and load_err are valid in the cycle after the edge that caused them, and are high for exactly one cycle.
- Changing up between edges is legal; only the value sampled at the edge matters. There is no glitch or extra count on a direction change.
- Invariant at every edge after reset: q_inverse == ~q and q < MODULO.
- No X propagation after the first reset edge. Before the first reset, outputs are undefined and the bench must not check them.
- All arithmetic is unsigned and WIDTH bits; no carry output beyond wrap.
- Every edge's work is fully registered; q, q_inverse, wrap and load_err have no combinational path from any input.

Test Plan (WIDTH=4, MODULO=10):
1. rst=1 for 2 edges with en=1, load=1, load_value=5 → q=0, q_inverse=4'hF, wrap=0, load_err=0.
2. en=1, up=1 from 0 for 12 edges → q goes 1..9,0,1,2. wrap=1 only in the cycle q becomes 0; q_inverse==~q every cycle.
3. en=1, up=0 from q=2 for 4 edges → q goes 1,0,9,8. wrap=1 only in the cycle q becomes 9.
4. load=1, load_value=7, en=1 → q=7, no count that edge. Then load_value=12 → q stays 7, load_err=1 for one cycle, then 0.
5. From q=5, en=1, up=1; rst=1 on the next edge → q=0, wrap=0. Counting resumes at 1 on the edge after rst drops.
6. From q=4 with en=0 for 5 edges → q=4 throughout, wrap=0. Toggle up each edge with en=1 → q goes 5,4,5,4.
